vga_scanout: RTL

Read-side scan engine for the 320x240x8 framebuffer. Generates 640x480@60 Hz VGA timing and issues full-resolution read coordinates to the buffer, which halves them internally. Takes the buffer's registered 8-bit pixel, expands RRRGGGBB to 24-bit RGB, and drives the DAC/connector pins with sync and blank aligned to the pixel data. Sits between the framebuffer read port and the board VGA pins.

---
 rtl/vga_scanout.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/vga_scanout.sv
// VGA 640x480@60 scan engine: timing counters, framebuffer read coordinates, RRRGGGBB expansion.
// Optional macro VGA_CLKDIV_EN: 50 MHz input clock with an internal divide-by-two pixel tick.
module vga_scanout #(
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  pixel_in,
    output logic [10:0] pix_x,
    output logic [10:0] pix_y,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n,
    output logic        vga_sync_n,
    output logic        vga_clk,
    output logic        frame_start
);

    localparam logic [10:0] H_VIS_L  = 11'(H_VIS);
    localparam logic [10:0] V_VIS_L  = 11'(V_VIS);
    localparam logic [10:0] H_LAST   = 11'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [10:0] V_LAST   = 11'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [10:0] HS_BEG   = 11'(H_VIS + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [10:0] VS_BEG   = 11'(V_VIS + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_VIS + V_FP + V_SYNC - 1);

    function automatic logic [7:0] expand3(input logic [2:0] c);
        expand3 = {c, c, c[2:1]};
    endfunction

    function automatic logic [7:0] expand2(input logic [1:0] c);
        expand2 = {c, c, c, c};
    endfunction

    logic        tick_s;
    logic        vis_s;
    logic [10:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [10:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic        vis_q, vis_d, hs_raw_q, hs_raw_d, vs_raw_q, vs_raw_d;
    logic        blank_d1_q, blank_d1_d, hs_d1_q, hs_d1_d, vs_d1_q, vs_d1_d;
    logic        blank_n_q, blank_n_d, hs_q, hs_d, vs_q, vs_d;
    logic [7:0]  r_q, r_d, g_q, g_d, b_q, b_d;
    logic        fs_q, fs_d;

`ifdef VGA_CLKDIV_EN
    logic tog_q, tog_d;

    // Divide-by-two toggle; the pixel tick falls on the clock where it is high.
    always_comb begin
        tog_d = ~tog_q;
    end

    // Toggle register, cleared so the first tick lands on the second clock after release.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tog_q <= 1'b0;
        end else begin
            tog_q <= tog_d;
        end
    end

    assign tick_s  = tog_q;
    assign vga_clk = tog_q;
`else
    assign tick_s  = 1'b1;
    assign vga_clk = ~clock;
`endif

    // Horizontal/vertical counters and the frame-wrap pulse.
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        fs_d    = 1'b0;
        if (tick_s) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = 11'd0;
                if (v_cnt_q == V_LAST) begin
                    v_cnt_d = 11'd0;
                    fs_d    = 1'b1;
                end else begin
                    v_cnt_d = v_cnt_q + 11'd1;
                end
            end else begin
                h_cnt_d = h_cnt_q + 11'd1;
            end
        end else begin
            h_cnt_d = h_cnt_q;
        end
    end

    // Coordinate stage: read address and raw sync/visible flags share one edge.
    always_comb begin
        vis_s    = (h_cnt_q < H_VIS_L) && (v_cnt_q < V_VIS_L);
        vis_d    = vis_s;
        pix_x_d  = vis_s ? h_cnt_q : 11'd0;
        pix_y_d  = vis_s ? v_cnt_q : 11'd0;
        hs_raw_d = !((h_cnt_q >= HS_BEG) && (h_cnt_q <= HS_END));
        vs_raw_d = !((v_cnt_q >= VS_BEG) && (v_cnt_q <= VS_END));
    end

    // Two-stage delay of sync/blank, and colour gated by the blank aligned with pixel_in.
    always_comb begin
        blank_d1_d = vis_q;
        hs_d1_d    = hs_raw_q;
        vs_d1_d    = vs_raw_q;
        blank_n_d  = blank_d1_q;
        hs_d       = hs_d1_q;
        vs_d       = vs_d1_q;
        if (blank_d1_q) begin
            r_d = expand3(pixel_in[7:5]);
            g_d = expand3(pixel_in[4:2]);
            b_d = expand2(pixel_in[1:0]);
        end else begin
            r_d = 8'd0;
            g_d = 8'd0;
            b_d = 8'd0;
        end
    end

    // All scan state; reset returns everything to the inactive, blanked condition.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            h_cnt_q    <= 11'd0;
            v_cnt_q    <= 11'd0;
            pix_x_q    <= 11'd0;
            pix_y_q    <= 11'd0;
            vis_q      <= 1'b0;
            hs_raw_q   <= 1'b1;
            vs_raw_q   <= 1'b1;
            blank_d1_q <= 1'b0;
            hs_d1_q    <= 1'b1;
            vs_d1_q    <= 1'b1;
            blank_n_q  <= 1'b0;
            hs_q       <= 1'b1;
            vs_q       <= 1'b1;
            r_q        <= 8'd0;
            g_q        <= 8'd0;
            b_q        <= 8'd0;
            fs_q       <= 1'b0;
        end else begin
            h_cnt_q    <= h_cnt_d;
            v_cnt_q    <= v_cnt_d;
            pix_x_q    <= pix_x_d;
            pix_y_q    <= pix_y_d;
            vis_q      <= vis_d;
            hs_raw_q   <= hs_raw_d;
            vs_raw_q   <= vs_raw_d;
            blank_d1_q <= blank_d1_d;
            hs_d1_q    <= hs_d1_d;
            vs_d1_q    <= vs_d1_d;
            blank_n_q  <= blank_n_d;
            hs_q       <= hs_d;
            vs_q       <= vs_d;
            r_q        <= r_d;
            g_q        <= g_d;
            b_q        <= b_d;
            fs_q       <= fs_d;
        end
    end

    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign vga_r       = r_q;
    assign vga_g       = g_q;
    assign vga_b       = b_q;
    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign vga_blank_n = blank_n_q;
    assign vga_sync_n  = 1'b0;
    assign frame_start = fs_q;

endmodule
